// File: rtl/geom_pkg.sv
// Shared geometry types and defaults for the screen-space triangle setup path.
// Vertices arrive as Q16.16 x/y/u/v with an 8-bit integer depth.
package geom_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int PIX_W_DEF    = 12;
    localparam int FRAC_BITS    = 16;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  z;
        logic [31:0] u;
        logic [31:0] v;
    } vertex_t;

    typedef struct packed {
        logic [2:0][PIX_W_DEF-1:0] px;
        logic [2:0][PIX_W_DEF-1:0] py;
        logic [2:0][7:0]           pz;
        logic [2:0][31:0]          pu;
        logic [2:0][31:0]          pv;
        logic [2*PIX_W_DEF+1:0]    area;
        logic [PIX_W_DEF-1:0]      bb_xmin;
        logic [PIX_W_DEF-1:0]      bb_xmax;
        logic [PIX_W_DEF-1:0]      bb_ymin;
        logic [PIX_W_DEF-1:0]      bb_ymax;
    } tri_t;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_AREA,
        S_CLIP,
        S_OUTPUT
    } asm_state_t;

endpackage

// File: rtl/tri_setup.sv
// Combinational triangle setup: doubled signed area, raw bounding box,
// off-screen test and the screen-clamped bounding box.
module tri_setup #(
    parameter int PIX_W    = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [2:0][PIX_W-1:0]    px,
    input  logic [2:0][PIX_W-1:0]    py,
    output logic signed [2*PIX_W+1:0] area,
    output logic [PIX_W-1:0]          bb_xmin,
    output logic [PIX_W-1:0]          bb_xmax,
    output logic [PIX_W-1:0]          bb_ymin,
    output logic [PIX_W-1:0]          bb_ymax,
    output logic                      offscreen
);

    localparam int AREA_W = 2*PIX_W+2;
    localparam logic signed [PIX_W-1:0] X_LAST = PIX_W'(SCREEN_W-1);
    localparam logic signed [PIX_W-1:0] Y_LAST = PIX_W'(SCREEN_H-1);

    logic signed [AREA_W-1:0] ex [3];
    logic signed [AREA_W-1:0] ey [3];
    logic signed [PIX_W-1:0]  xmin, xmax, ymin, ymax;

    function automatic logic signed [PIX_W-1:0] min3(input logic signed [PIX_W-1:0] a,
                                                     input logic signed [PIX_W-1:0] b,
                                                     input logic signed [PIX_W-1:0] c);
        logic signed [PIX_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [PIX_W-1:0] max3(input logic signed [PIX_W-1:0] a,
                                                     input logic signed [PIX_W-1:0] b,
                                                     input logic signed [PIX_W-1:0] c);
        logic signed [PIX_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [PIX_W-1:0] clamp(input logic signed [PIX_W-1:0] val,
                                               input logic signed [PIX_W-1:0] hi);
        if (val < 0)
            return '0;
        else if (val > hi)
            return hi;
        else
            return val;
    endfunction

    // Sign-extend to full area width so the cross product cannot overflow early.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ext
        assign ex[gi] = AREA_W'($signed(px[gi]));
        assign ey[gi] = AREA_W'($signed(py[gi]));
    end

    always_comb begin
        area = (ex[1] - ex[0]) * (ey[2] - ey[0]) - (ex[2] - ex[0]) * (ey[1] - ey[0]);
        xmin = min3($signed(px[0]), $signed(px[1]), $signed(px[2]));
        xmax = max3($signed(px[0]), $signed(px[1]), $signed(px[2]));
        ymin = min3($signed(py[0]), $signed(py[1]), $signed(py[2]));
        ymax = max3($signed(py[0]), $signed(py[1]), $signed(py[2]));
        offscreen = (xmax < 0) || (xmin > X_LAST) || (ymax < 0) || (ymin > Y_LAST);
        bb_xmin = clamp(xmin, X_LAST);
        bb_xmax = clamp(xmax, X_LAST);
        bb_ymin = clamp(ymin, Y_LAST);
        bb_ymax = clamp(ymax, Y_LAST);
    end

endmodule

// File: rtl/triangle_assembler.sv
// Groups consecutive vertices into triangles, culls back-facing, degenerate
// and off-screen ones, and presents survivors to the rasterizer.
module triangle_assembler
    import geom_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF,
    parameter int CULL_BACK = 1,
    parameter int PIX_W     = PIX_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_vtx_valid,
    output logic                      o_vtx_ready,
    input  logic [31:0]               i_x,
    input  logic [31:0]               i_y,
    input  logic [7:0]                i_z,
    input  logic [31:0]               i_u,
    input  logic [31:0]               i_v,
    output logic                      o_tri_valid,
    input  logic                      i_tri_ready,
    output logic [2:0][PIX_W-1:0]     o_px,
    output logic [2:0][PIX_W-1:0]     o_py,
    output logic [2:0][7:0]           o_pz,
    output logic [2:0][31:0]          o_pu,
    output logic [2:0][31:0]          o_pv,
    output logic signed [2*PIX_W+1:0] o_area,
    output logic [PIX_W-1:0]          o_bb_xmin,
    output logic [PIX_W-1:0]          o_bb_xmax,
    output logic [PIX_W-1:0]          o_bb_ymin,
    output logic [PIX_W-1:0]          o_bb_ymax,
    output logic [15:0]               o_tri_count,
    output logic [15:0]               o_cull_count
);

    localparam int AREA_W = 2*PIX_W+2;

    asm_state_t state_reg, state_next;
    logic [1:0] idx_reg;
    logic       vtx_fire;
    logic [2:0] slot_hit;
    vertex_t    vtx_in;

    logic [2:0][PIX_W-1:0] px_reg, py_reg;
    logic [2:0][7:0]       pz_reg;
    logic [2:0][31:0]      pu_reg, pv_reg;

    logic signed [AREA_W-1:0] area_comb, area_reg;
    logic [PIX_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic             offscreen;
    logic             drop;

    assign vtx_in      = '{x: i_x, y: i_y, z: i_z, u: i_u, v: i_v};
    assign o_vtx_ready = (state_reg == S_COLLECT);
    assign vtx_fire    = i_vtx_valid && o_vtx_ready;

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        assign slot_hit[gi] = vtx_fire && (idx_reg == 2'(gi));
    end

    // Pixel coordinate is the floor of the Q16.16 value, truncated to PIX_W.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_reg <= '0;
            px_reg  <= '0;
            py_reg  <= '0;
            pz_reg  <= '0;
            pu_reg  <= '0;
            pv_reg  <= '0;
        end else begin
            if (vtx_fire)
                idx_reg <= (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
            for (int i = 0; i < 3; i++) begin
                if (slot_hit[i]) begin
                    px_reg[i] <= vtx_in.x[FRAC_BITS +: PIX_W];
                    py_reg[i] <= vtx_in.y[FRAC_BITS +: PIX_W];
                    pz_reg[i] <= vtx_in.z;
                    pu_reg[i] <= vtx_in.u;
                    pv_reg[i] <= vtx_in.v;
                end
            end
        end
    end

    tri_setup #(
        .PIX_W    (PIX_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_setup (
        .px        (px_reg),
        .py        (py_reg),
        .area      (area_comb),
        .bb_xmin   (bb_xmin),
        .bb_xmax   (bb_xmax),
        .bb_ymin   (bb_ymin),
        .bb_ymax   (bb_ymax),
        .offscreen (offscreen)
    );

    assign drop = (area_reg == '0) || ((CULL_BACK != 0) && area_reg[AREA_W-1]) || offscreen;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_reg <= S_COLLECT;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_COLLECT: if (vtx_fire && idx_reg == 2'd2) state_next = S_AREA;
            S_AREA:    state_next = S_CLIP;
            S_CLIP:    state_next = drop ? S_COLLECT : S_OUTPUT;
            S_OUTPUT:  if (i_tri_ready) state_next = S_COLLECT;
            default:   state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            area_reg     <= '0;
            o_tri_valid  <= 1'b0;
            o_px         <= '0;
            o_py         <= '0;
            o_pz         <= '0;
            o_pu         <= '0;
            o_pv         <= '0;
            o_area       <= '0;
            o_bb_xmin    <= '0;
            o_bb_xmax    <= '0;
            o_bb_ymin    <= '0;
            o_bb_ymax    <= '0;
            o_tri_count  <= '0;
            o_cull_count <= '0;
        end else begin
            if (state_reg == S_AREA)
                area_reg <= area_comb;
            if (state_reg == S_CLIP) begin
                if (drop) begin
                    o_cull_count <= o_cull_count + 16'd1;
                end else begin
                    o_px        <= px_reg;
                    o_py        <= py_reg;
                    o_pz        <= pz_reg;
                    o_pu        <= pu_reg;
                    o_pv        <= pv_reg;
                    o_area      <= area_reg;
                    o_bb_xmin   <= bb_xmin;
                    o_bb_xmax   <= bb_xmax;
                    o_bb_ymin   <= bb_ymin;
                    o_bb_ymax   <= bb_ymax;
                    o_tri_valid <= 1'b1;
                end
            end
            if (state_reg == S_OUTPUT && i_tri_ready) begin
                o_tri_valid <= 1'b0;
                o_tri_count <= o_tri_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench: two assemblers (back-face culling on and off) sharing vertex data.
module tb_triangle_assembler;

    logic        clk;
    logic        rst;
    logic [31:0] x, y, u, v;
    logic [7:0]  z;

    logic        valid_a, vready_a, tvalid_a, tready_a;
    logic [2:0][11:0] px_a, py_a;
    logic [2:0][7:0]  pz_a;
    logic [2:0][31:0] pu_a, pv_a;
    logic signed [25:0] area_a;
    logic [11:0] bxmin_a, bxmax_a, bymin_a, bymax_a;
    logic [15:0] tcnt_a, ccnt_a;

    logic        valid_b, vready_b, tvalid_b, tready_b;
    logic [2:0][11:0] px_b, py_b;
    logic [2:0][7:0]  pz_b;
    logic [2:0][31:0] pu_b, pv_b;
    logic signed [25:0] area_b;
    logic [11:0] bxmin_b, bxmax_b, bymin_b, bymax_b;
    logic [15:0] tcnt_b, ccnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    triangle_assembler #(.CULL_BACK(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_vtx_valid(valid_a), .o_vtx_ready(vready_a),
        .i_x(x), .i_y(y), .i_z(z), .i_u(u), .i_v(v),
        .o_tri_valid(tvalid_a), .i_tri_ready(tready_a),
        .o_px(px_a), .o_py(py_a), .o_pz(pz_a), .o_pu(pu_a), .o_pv(pv_a), .o_area(area_a),
        .o_bb_xmin(bxmin_a), .o_bb_xmax(bxmax_a), .o_bb_ymin(bymin_a), .o_bb_ymax(bymax_a),
        .o_tri_count(tcnt_a), .o_cull_count(ccnt_a)
    );

    triangle_assembler #(.CULL_BACK(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_vtx_valid(valid_b), .o_vtx_ready(vready_b),
        .i_x(x), .i_y(y), .i_z(z), .i_u(u), .i_v(v),
        .o_tri_valid(tvalid_b), .i_tri_ready(tready_b),
        .o_px(px_b), .o_py(py_b), .o_pz(pz_b), .o_pu(pu_b), .o_pv(pv_b), .o_area(area_b),
        .o_bb_xmin(bxmin_b), .o_bb_xmax(bxmax_b), .o_bb_ymin(bymin_b), .o_bb_ymax(bymax_b),
        .o_tri_count(tcnt_b), .o_cull_count(ccnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic send_vtx(input int sel, input int xi, input int yi, input int zi);
        int n;
        x = xi <<< 16;
        y = yi <<< 16;
        z = 8'(zi);
        u = xi * 3;
        v = yi * 5;
        if (sel == 0) valid_a = 1'b1; else valid_b = 1'b1;
        n = 0;
        while (((sel == 0) ? vready_a : vready_b) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("vtx_accept_timeout", n, 0);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output int lat);
        lat = 0;
        while (((sel == 0) ? tvalid_a : tvalid_b) !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop(input int sel);
        if (sel == 0) tready_a = 1'b1; else tready_b = 1'b1;
        @(negedge clk);
        tready_a = 1'b0;
        tready_b = 1'b0;
    endtask

    task automatic watch_none(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tvalid_a === 1'b1) seen = 1;
        end
    endtask

    initial begin
        int lat;
        int seen;
        longint s_area, s_px0, s_bxmax;

        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        tready_a = 1'b0; tready_b = 1'b0;
        x = '0; y = '0; z = '0; u = '0; v = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_vtx_ready", vready_a, 1);
        check_eq("rst_tri_valid", tvalid_a, 0);
        check_eq("rst_tri_count", tcnt_a, 0);
        check_eq("rst_area", longint'(area_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // Counter-clockwise front face
        send_vtx(0, 10, 10, 5);
        send_vtx(0, 50, 10, 6);
        send_vtx(0, 10, 50, 7);
        wait_valid(0, lat);
        check_eq("ccw_latency", lat, 2);
        check_eq("ccw_area", longint'(area_a), 1600);
        check_eq("ccw_bb_xmin", bxmin_a, 10);
        check_eq("ccw_bb_xmax", bxmax_a, 50);
        check_eq("ccw_bb_ymin", bymin_a, 10);
        check_eq("ccw_bb_ymax", bymax_a, 50);
        check_eq("ccw_px1", px_a[1], 50);
        check_eq("ccw_py2", py_a[2], 50);
        check_eq("ccw_pz2", pz_a[2], 7);
        check_eq("ccw_pu1", pu_a[1], 150);
        check_eq("ccw_pv2", pv_a[2], 250);
        pop(0);
        check_eq("ccw_valid_drop", tvalid_a, 0);
        check_eq("ccw_tri_count", tcnt_a, 1);

        // Reversed winding, culled on A
        send_vtx(0, 10, 10, 1);
        send_vtx(0, 10, 50, 1);
        send_vtx(0, 50, 10, 1);
        watch_none(5, seen);
        check_eq("rev_cull_no_valid", seen, 0);
        check_eq("rev_cull_count", ccnt_a, 1);
        check_eq("rev_cull_tri_count", tcnt_a, 1);

        // Reversed winding, kept on B
        send_vtx(1, 10, 10, 1);
        send_vtx(1, 10, 50, 1);
        send_vtx(1, 50, 10, 1);
        wait_valid(1, lat);
        check_eq("rev_keep_latency", lat, 2);
        check_eq("rev_keep_area", longint'(area_b), -1600);
        check_eq("rev_keep_bb_xmax", bxmax_b, 50);
        pop(1);
        check_eq("rev_keep_tri_count", tcnt_b, 1);
        check_eq("rev_keep_cull_count", ccnt_b, 0);

        // Edge clamp
        send_vtx(0, 630, 470, 2);
        send_vtx(0, 700, 470, 2);
        send_vtx(0, 630, 500, 2);
        wait_valid(0, lat);
        check_eq("clamp_area", longint'(area_a), 2100);
        check_eq("clamp_bb_xmin", bxmin_a, 630);
        check_eq("clamp_bb_xmax", bxmax_a, 639);
        check_eq("clamp_bb_ymin", bymin_a, 470);
        check_eq("clamp_bb_ymax", bymax_a, 479);
        check_eq("clamp_px1_raw", px_a[1], 700);
        pop(0);
        check_eq("clamp_tri_count", tcnt_a, 2);

        // Fully off-screen, then degenerate collinear
        send_vtx(0, -100, -100, 3);
        send_vtx(0, -50, -100, 3);
        send_vtx(0, -100, -50, 3);
        watch_none(5, seen);
        check_eq("offscreen_no_valid", seen, 0);
        send_vtx(0, 0, 0, 3);
        send_vtx(0, 10, 10, 3);
        send_vtx(0, 20, 20, 3);
        watch_none(5, seen);
        check_eq("degen_no_valid", seen, 0);
        check_eq("drop_cull_count", ccnt_a, 3);

        // Backpressure: rasterizer stalls while a vertex is offered
        send_vtx(0, 10, 10, 4);
        send_vtx(0, 50, 10, 4);
        send_vtx(0, 10, 50, 4);
        wait_valid(0, lat);
        s_area  = longint'(area_a);
        s_px0   = px_a[0];
        s_bxmax = bxmax_a;
        x = 20 <<< 16; y = 20 <<< 16; z = 8'd9; u = 60; v = 100;
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_vtx_ready", vready_a, 0);
            check_eq("bp_tri_valid", tvalid_a, 1);
            check_eq("bp_area_hold", longint'(area_a), s_area);
            check_eq("bp_px0_hold", px_a[0], s_px0);
            check_eq("bp_bxmax_hold", bxmax_a, s_bxmax);
        end
        tready_a = 1'b1;
        @(negedge clk);
        tready_a = 1'b0;
        check_eq("bp_release_valid", tvalid_a, 0);
        check_eq("bp_release_vready", vready_a, 1);
        check_eq("bp_tri_count", tcnt_a, 3);
        @(negedge clk);
        valid_a = 1'b0;
        send_vtx(0, 60, 20, 9);
        send_vtx(0, 20, 60, 9);
        wait_valid(0, lat);
        check_eq("bp_next_latency", lat, 2);
        check_eq("bp_next_px0", px_a[0], 20);
        check_eq("bp_next_pz0", pz_a[0], 9);
        check_eq("bp_next_area", longint'(area_a), 1600);
        check_eq("bp_next_bb_xmin", bxmin_a, 20);
        check_eq("bp_next_bb_xmax", bxmax_a, 60);
        pop(0);

        // Reset after a partial group
        send_vtx(0, 100, 100, 1);
        send_vtx(0, 200, 100, 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_tri_count", tcnt_a, 0);
        check_eq("mid_rst_cull_count", ccnt_a, 0);
        check_eq("mid_rst_vready", vready_a, 1);
        check_eq("mid_rst_bb_xmax", bxmax_a, 0);
        send_vtx(0, 10, 10, 5);
        send_vtx(0, 50, 10, 6);
        send_vtx(0, 10, 50, 7);
        wait_valid(0, lat);
        check_eq("fresh_latency", lat, 2);
        check_eq("fresh_area", longint'(area_a), 1600);
        check_eq("fresh_px0", px_a[0], 10);
        check_eq("fresh_px1", px_a[1], 50);
        pop(0);
        check_eq("fresh_tri_count", tcnt_a, 1);
        check_eq("fresh_cull_count", ccnt_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
